reg_file_mp: RTL

Parametrised multi-read-port register file with a per-register pending-write scoreboard, the next generation of the processor's 32×32 register file. Writes commit on the rising clock edge. Reads are combinational, with same-cycle write-through bypass. Register 0 is optionally hardwired to zero. The block sits between decode (read ports, issue marking) and writeback (write port), and gives the hazard/stall logic a per-port busy flag.

---
 rtl/reg_file_mp_pkg.sv | 13 +
 rtl/reg_file_mp_if.sv | 28 ++
 rtl/reg_file_mp_scoreboard.sv | 78 +++++++
 rtl/reg_file_mp.sv | 69 ++++++
 4 files changed

// File: rtl/reg_file_mp_pkg.sv
// Shared parameters and helpers for the multi-port register file.
package regfile_pkg;

    // Default register width and address width (32 x 32 register file).
    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;

    // Bit offset of a port's field inside a flattened multi-port vector.
    function automatic int rf_slice(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Bus bundle between decode/writeback (master) and the register file (slave).
// There is no handshake: every enabled write or issue is accepted on the
// clock edge where it is presented, and reads are combinational.
interface reg_file_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     iss_en;
    logic [ADDR_W-1:0]        iss_addr;
    logic [ADDR_W:0]          pend_cnt;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        input  rd_data, rd_busy, pend_cnt
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        output rd_data, rd_busy, pend_cnt
    );
endinterface

// File: rtl/reg_file_mp_scoreboard.sv
// Pending-write scoreboard: one bit per register, set at issue, cleared at
// writeback, with a registered population count and per-port busy lookup.
module reg_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     iss_en_i,
    input  logic [ADDR_W-1:0]        iss_addr_i,
    input  logic                     wr_en_i,
    input  logic [ADDR_W-1:0]        wr_addr_i,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    output logic [NUM_RD-1:0]        rd_busy_o,
    output logic [ADDR_W:0]          pend_cnt_o
);
    localparam int             DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W + 1)'(1);

    logic [DEPTH-1:0] pend_q, pend_d;
    logic [ADDR_W:0]  cnt_q, cnt_d;
    logic             set_ok, clr_ok, inc, dec;

    // Next pending vector and count; issue is applied after clear so that a
    // same-address issue/writeback leaves the newer producer outstanding.
    always_comb begin
        set_ok = iss_en_i && !((ZERO_REG != 0) && (iss_addr_i == '0));
        clr_ok = wr_en_i  && !((ZERO_REG != 0) && (wr_addr_i  == '0));
        inc    = set_ok && !pend_q[iss_addr_i];
        dec    = clr_ok && pend_q[wr_addr_i] && !(set_ok && (iss_addr_i == wr_addr_i));

        pend_d = pend_q;
        if (clr_ok) pend_d[wr_addr_i]  = 1'b0;
        if (set_ok) pend_d[iss_addr_i] = 1'b1;

        cnt_d = cnt_q;
        if (inc && !dec)      cnt_d = cnt_q + CNT_ONE;
        else if (dec && !inc) cnt_d = cnt_q - CNT_ONE;
    end

    // Pending vector and its population count update on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    assign pend_cnt_o = cnt_q;

    // Per-port busy: a writeback in this cycle hides the stored bit unless a
    // new issue to the same register arrives alongside it.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_busy
        localparam int OFF = rf_slice(k, ADDR_W);
        logic [ADDR_W-1:0] addr;
        logic              busy;

        assign addr = rd_addr_i[OFF +: ADDR_W];

        // Busy lookup with zero-register and writeback bypass terms.
        always_comb begin
            busy = pend_q[addr];
            if ((ZERO_REG != 0) && (addr == '0))
                busy = 1'b0;
            else if (rst_n && wr_en_i && (wr_addr_i == addr))
                busy = iss_en_i && (iss_addr_i == addr);
        end

        assign rd_busy_o[k] = busy;
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with write-through bypass and a
// pending-write scoreboard feeding the hazard/stall logic.
module reg_file_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    reg_file_mp_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              wr_ok;

    // Writes to register 0 are dropped when it is hardwired to zero.
    assign wr_ok = bus.wr_en && !((ZERO_REG != 0) && (bus.wr_addr == '0));

    // Storage array: cleared on reset, one write per cycle otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_ok) begin
            mem_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Read ports: zero register, then same-cycle writeback bypass, then storage.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        localparam int OFF_A = rf_slice(k, ADDR_W);
        localparam int OFF_D = rf_slice(k, DATA_W);
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;

        assign addr = bus.rd_addr[OFF_A +: ADDR_W];

        // Read mux; bypass is suppressed while in reset since writes are ignored.
        always_comb begin
            data = mem_q[addr];
            if ((ZERO_REG != 0) && (addr == '0))
                data = '0;
            else if (rst_n && bus.wr_en && (bus.wr_addr == addr))
                data = bus.wr_data;
        end

        assign bus.rd_data[OFF_D +: DATA_W] = data;
    end

    reg_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .iss_en_i   (bus.iss_en),
        .iss_addr_i (bus.iss_addr),
        .wr_en_i    (bus.wr_en),
        .wr_addr_i  (bus.wr_addr),
        .rd_addr_i  (bus.rd_addr),
        .rd_busy_o  (bus.rd_busy),
        .pend_cnt_o (bus.pend_cnt)
    );

endmodule
